// File: rtl/param_ring_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_ring_fifo
// Purpose  : Parametrised FWFT ring-buffer FIFO with status and sticky errors.
// Revision : 1.0
// ============================================================================
module param_ring_fifo #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 16,
   parameter int AFULL_LEVEL = DEPTH - 2,
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             write_en,
   input  logic             read_en,
   input  logic             flush,
   input  logic             clear_err,
   output logic [WIDTH-1:0] dout,
   output logic             available,
   output logic             full,
   output logic             almost_full,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             underflow
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LEVEL);

   if (DEPTH < 2 || AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_param_check
      $error("param_ring_fifo: DEPTH must be >= 2 and AFULL_LEVEL within 1..DEPTH");
   end

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             rd_ok;
   logic             wr_ok;
   logic             ovf_set;
   logic             unf_set;

   assign rd_ok   = read_en & (count != '0);
   assign wr_ok   = write_en & ((count != DEPTH_C) | rd_ok);
   // A flush swallows that cycle's requests, so they cannot raise errors either.
   assign ovf_set = write_en & ~wr_ok & ~flush;
   assign unf_set = read_en & ~rd_ok & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_ok && !rd_ok)
               count <= count + 1'b1;
            else if (rd_ok && !wr_ok)
               count <= count - 1'b1;
         end
         overflow  <= (overflow & ~clear_err) | ovf_set;
         underflow <= (underflow & ~clear_err) | unf_set;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !flush)
         mem[wr_ptr] <= din;
   end

   assign available   = (count != '0);
   assign full        = (count == DEPTH_C);
   assign almost_full = (count >= AFULL_C);
   assign dout        = available ? mem[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_param_ring_fifo.sv
`default_nettype none
// Directed bench: DEPTH=8 instance for main behaviour, DEPTH=5 instance for wrap-around.
module tb_param_ring_fifo;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] a_din = '0;
   logic a_we = 0, a_re = 0, a_fl = 0, a_ce = 0;
   logic [7:0] a_dout;
   logic a_av, a_full, a_af, a_ov, a_un;
   logic [3:0] a_cnt;

   logic [7:0] b_din = '0;
   logic b_we = 0, b_re = 0, b_fl = 0, b_ce = 0;
   logic [7:0] b_dout;
   logic b_av, b_full, b_af, b_ov, b_un;
   logic [2:0] b_cnt;

   param_ring_fifo #(.WIDTH(8), .DEPTH(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .din(a_din), .write_en(a_we), .read_en(a_re),
      .flush(a_fl), .clear_err(a_ce), .dout(a_dout), .available(a_av),
      .full(a_full), .almost_full(a_af), .count(a_cnt),
      .overflow(a_ov), .underflow(a_un));

   param_ring_fifo #(.WIDTH(8), .DEPTH(5), .AFULL_LEVEL(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .din(b_din), .write_en(b_we), .read_en(b_re),
      .flush(b_fl), .clear_err(b_ce), .dout(b_dout), .available(b_av),
      .full(b_full), .almost_full(b_af), .count(b_cnt),
      .overflow(b_ov), .underflow(b_un));

   int total = 0;
   int passed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic a_step(input logic we, input logic [7:0] d, input logic re,
                         input logic fl, input logic ce);
      a_we = we; a_din = d; a_re = re; a_fl = fl; a_ce = ce;
      @(posedge clk); #1;
      a_we = 0; a_re = 0; a_fl = 0; a_ce = 0;
   endtask

   task automatic b_step(input logic we, input logic [7:0] d, input logic re);
      b_we = we; b_din = d; b_re = re;
      @(posedge clk); #1;
      b_we = 0; b_re = 0;
   endtask

   logic [7:0] exp_a [8];

   initial begin
      exp_a = '{8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3};

      // Reset state
      #2;
      chk("rst_cnt", a_cnt, 0);
      chk("rst_av", a_av, 0);
      chk("rst_dout", a_dout, 0);
      chk("rst_full", a_full, 0);
      chk("rst_af", a_af, 0);
      chk("rst_ov", a_ov, 0);
      chk("rst_un", a_un, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Four consecutive writes; first word visible right after its edge
      a_step(1, 8'd10, 0, 0, 0);
      chk("w1_av", a_av, 1);
      chk("w1_dout", a_dout, 10);
      chk("w1_cnt", a_cnt, 1);
      a_step(1, 8'd9, 0, 0, 0);
      a_step(1, 8'd8, 0, 0, 0);
      a_step(1, 8'd7, 0, 0, 0);
      chk("w4_cnt", a_cnt, 4);
      chk("w4_dout", a_dout, 10);
      chk("w4_ov", a_ov, 0);
      chk("w4_un", a_un, 0);

      // Fill to 8; almost_full (level 6) rises at count 6
      for (int i = 4; i < 8; i++) begin
         a_step(1, exp_a[i], 0, 0, 0);
         chk("fill_cnt", a_cnt, i + 1);
         chk("fill_af", a_af, (i + 1) >= 6);
         chk("fill_full", a_full, (i + 1) == 8);
      end

      // Write to full FIFO is rejected
      a_step(1, 8'h55, 0, 0, 0);
      chk("ovf_full", a_full, 1);
      chk("ovf_flag", a_ov, 1);
      chk("ovf_cnt", a_cnt, 8);

      // Drain: order preserved, 0x55 absent
      for (int i = 0; i < 8; i++) begin
         chk("drain_dout", a_dout, exp_a[i]);
         a_step(0, 8'h00, 1, 0, 0);
      end
      chk("drain_av", a_av, 0);
      chk("drain_dout0", a_dout, 0);
      chk("drain_cnt", a_cnt, 0);
      chk("drain_un", a_un, 0);
      a_step(0, 8'h00, 0, 0, 1);
      chk("clr_ov", a_ov, 0);

      // Full FIFO, simultaneous read and write
      for (int i = 0; i < 8; i++) a_step(1, 8'h10 + 8'(i), 0, 0, 0);
      a_step(1, 8'hAA, 1, 0, 0);
      chk("rw_full_cnt", a_cnt, 8);
      chk("rw_full_ov", a_ov, 0);
      for (int i = 0; i < 8; i++) begin
         chk("rw_full_dout", a_dout, (i == 7) ? 8'hAA : 8'h11 + 8'(i));
         a_step(0, 8'h00, 1, 0, 0);
      end
      chk("rw_full_empty", a_av, 0);

      // Empty FIFO, simultaneous read and write: no bypass
      a_step(1, 8'h33, 1, 0, 0);
      chk("rw_empty_un", a_un, 1);
      chk("rw_empty_cnt", a_cnt, 1);
      chk("rw_empty_dout", a_dout, 8'h33);
      chk("rw_empty_ov", a_ov, 0);

      // clear_err together with a new underflow: set wins
      a_step(0, 8'h00, 1, 0, 0);
      a_step(0, 8'h00, 1, 0, 1);
      chk("setwins_un", a_un, 1);
      a_step(0, 8'h00, 0, 0, 1);
      chk("clr_un", a_un, 0);

      // Flush with write_en: contents dropped, flags untouched
      a_step(0, 8'h00, 1, 0, 0);
      for (int i = 1; i <= 5; i++) a_step(1, 8'(i), 0, 0, 0);
      chk("pre_flush_cnt", a_cnt, 5);
      a_step(1, 8'h77, 0, 1, 0);
      chk("flush_cnt", a_cnt, 0);
      chk("flush_av", a_av, 0);
      chk("flush_dout", a_dout, 0);
      chk("flush_un", a_un, 1);
      chk("flush_ov", a_ov, 0);
      a_step(1, 8'h21, 0, 0, 0);
      chk("post_flush_dout", a_dout, 8'h21);
      chk("post_flush_cnt", a_cnt, 1);

      // DEPTH=5 wrap-around, 3-in/3-out, almost_full at 3
      for (int r = 0; r < 4; r++) begin
         for (int j = 0; j < 3; j++) begin
            b_step(1, 8'hC0 + 8'(3 * r + j), 0);
            chk("b_wr_cnt", b_cnt, j + 1);
            chk("b_wr_af", b_af, (j + 1) == 3);
         end
         for (int j = 0; j < 3; j++) begin
            chk("b_rd_dout", b_dout, 8'hC0 + 8'(3 * r + j));
            b_step(0, 8'h00, 1);
            chk("b_rd_cnt", b_cnt, 2 - j);
            chk("b_rd_af", b_af, 0);
         end
      end
      chk("b_ov", b_ov, 0);
      chk("b_un", b_un, 0);

      // Asynchronous reset mid-burst
      a_we = 1; a_din = 8'h40;
      @(posedge clk); #1;
      chk("burst_cnt", a_cnt, 2);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_cnt", a_cnt, 0);
      chk("arst_av", a_av, 0);
      chk("arst_dout", a_dout, 0);
      chk("arst_full", a_full, 0);
      chk("arst_af", a_af, 0);
      chk("arst_un", a_un, 0);
      chk("arst_ov", a_ov, 0);
      a_we = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #2;
      a_step(0, 8'h00, 1, 0, 0);
      chk("post_rst_un", a_un, 1);
      a_step(0, 8'h00, 0, 0, 1);
      chk("final_un", a_un, 0);
      chk("final_ov", a_ov, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/param_ring_fifo.md
Name: param_ring_fifo

Overview:
- Parametrised successor to the 8-bit ring buffer that sits between the UART receiver and the RPN parser, and between the evaluator and the UART transmitter.
- Adds configurable width and depth, full/almost-full/count status, sticky overflow/underflow error flags, and a synchronous flush.
- First-word-fall-through read: the head word is visible on dout whenever available is high.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2; need not be a power of two)
AFULL_LEVEL, DEPTH-2, almost_full asserts when count >= AFULL_LEVEL (1..DEPTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
din  input  WIDTH  write data
write_en  input  1  write request
read_en  input  1  read request (pops the current head)
flush  input  1  synchronous clear of contents and pointers
clear_err  input  1  synchronous clear of overflow/underflow
dout  output  WIDTH  head word (FWFT); 0 when empty
available  output  1  FIFO holds >=1 word (!empty)
full  output  1  count == DEPTH
almost_full  output  1  count >= AFULL_LEVEL
count  output  CNT_W  words stored, CNT_W = $clog2(DEPTH+1)
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0: wr_ptr=rd_ptr=0, count=0, available=0, full=0, almost_full=0, overflow=0, underflow=0, dout=0. Storage contents are not reset. Reset mid-operation discards all stored data immediately.
- Pointers: PTR_W = $clog2(DEPTH). A pointer increments by 1 and wraps from DEPTH-1 to 0 by explicit compare, not by natural overflow.
- Accept rules, evaluated on the rising edge from pre-edge state:
  - rd_ok = read_en & (count != 0).
  - wr_ok = write_en & ((count != DEPTH) | rd_ok). A write to a full FIFO is accepted when a read is accepted in the same cycle.
  - A read of an empty FIFO is always rejected. There is no write-to-read bypass, even with simultaneous write_en.
- Update:
  - wr_ok: mem[wr_ptr] <= din; wr_ptr advances.
  - rd_ok: rd_ptr advances.
  - count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Latency:
  - A word written at edge N appears on dout with available=1 after edge N (visible in cycle N+1) when the FIFO was empty.
  - Reading at edge N presents the next word in cycle N+1.
  - dout = mem[rd_ptr] when count != 0, else 0. It is combinational from registered state only; no din-to-dout path.
- Status outputs are registered or derived purely from registered count. They reflect the post-edge state with no additional cycle of lag.
- Errors:
  - overflow <= 1 when write_en & !wr_ok.
  - underflow <= 1 when read_en & !rd_ok.
  - Both hold until clear_err=1 or reset. If clear_err and a new error occur in the same cycle, the flag stays 1 (set wins).
- flush has priority over read and write that cycle. It sets pointers and count to 0. Data presented with write_en in the flush cycle is dropped and does not set overflow. Error flags are unaffected by flush.
- Out-of-range parameters (DEPTH<2, AFULL_LEVEL outside 1..DEPTH) are stopped with an elaboration-time $error.

Decomposition:
- No shared package needed. PTR_W and CNT_W are localparams computed in the module.
- No sub-module. Storage is an inferred register array inside the block; the pointer-increment-with-wrap is a local function used by both pointers.

Test Plan:
- DEPTH=8, WIDTH=8: reset, then write 10,9,8,7 on consecutive cycles -> count=4, available=1, dout=10 in the cycle after the first write; no errors.
- Fill to 8 words, then write 0x55 alone -> full=1, overflow=1, count stays 8, and the word is not stored. Read all 8 -> order preserved, available=0 after the last read, dout=0.
- Full FIFO with simultaneous read_en and write_en (0xAA) -> count stays 8, overflow stays 0, 0xAA emerges as the 8th subsequent read.
- Empty FIFO with simultaneous read_en and write_en (0x33) -> underflow=1, count=1, dout=0x33 next cycle.
- DEPTH=5 (non-power-of-two): push/pop 12 words in a 3-in/3-out pattern -> wrap-around preserves order; almost_full (AFULL_LEVEL=3) toggles exactly at count 3.
- With 5 stored words, assert flush together with write_en -> count=0, available=0, flags unchanged. Assert rst_n=0 mid-burst -> all outputs 0 asynchronously, before the next clock edge. Then assert clear_err -> overflow=underflow=0.
